// File: rtl/series_trend_monitor.sv
// Classifies a flagged sample series into rising/falling runs with sticky fault capture.
// Optional peak/trough tracking is compiled in with the TREND_PEAK_EN macro.
module series_trend_monitor #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8,
    parameter int RUN_THRESH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              incr,
    input  logic              decr,
    input  logic              error,
    input  logic              clr,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  run_len,
    output logic [CNT_W-1:0]  incr_cnt,
    output logic [CNT_W-1:0]  decr_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              trend_alarm,
    output logic              fault,
    output logic [DATA_W-1:0] peak,
    output logic [DATA_W-1:0] trough
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RISE  = 2'b01,
        FALL  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t             st, st_n;
    logic [CNT_W-1:0]   run_n, incr_n, decr_n, err_n;
    logic               fault_ev, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign fault_ev = error | (incr & decr);
    assign accept   = !fault_ev && (st != FAULT) && (incr | decr);
    assign state    = st;

    always_comb begin
        st_n   = st;
        run_n  = run_len;
        incr_n = incr_cnt;
        decr_n = decr_cnt;
        err_n  = err_cnt;
        if (fault_ev) begin
            st_n  = FAULT;
            run_n = '0;
            err_n = sat_inc(err_cnt);
        end else if (st == FAULT) begin
            st_n = FAULT;
        end else if (incr) begin
            st_n   = RISE;
            run_n  = (st == RISE) ? sat_inc(run_len) : CNT_W'(1);
            incr_n = sat_inc(incr_cnt);
        end else if (decr) begin
            st_n   = FALL;
            run_n  = (st == FALL) ? sat_inc(run_len) : CNT_W'(1);
            decr_n = sat_inc(decr_cnt);
        end else begin
            st_n  = IDLE;
            run_n = '0;
        end
    end

    // Alarm and fault are registered from next-state values so they align with state/run_len.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            st          <= IDLE;
            run_len     <= '0;
            incr_cnt    <= '0;
            decr_cnt    <= '0;
            err_cnt     <= '0;
            trend_alarm <= 1'b0;
            fault       <= 1'b0;
        end else begin
            st          <= st_n;
            run_len     <= run_n;
            incr_cnt    <= incr_n;
            decr_cnt    <= decr_n;
            err_cnt     <= err_n;
            trend_alarm <= ((st_n == RISE) || (st_n == FALL)) && (run_n >= CNT_W'(RUN_THRESH));
            fault       <= (st_n == FAULT);
        end
    end

`ifdef TREND_PEAK_EN
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            peak   <= '0;
            trough <= '1;
        end else if (accept) begin
            if (data > peak)   peak   <= data;
            if (data < trough) trough <= data;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{data, accept};
    assign peak   = '0;
    assign trough = '1;
`endif

endmodule
